mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
Parametrised N-channel, W-bit registered multiplexer with a valid/ready output handshake. It is the successor to the combinational 4:1 mux. It adds two things: a manual mode (select-driven) and an auto-scan mode, in which an internal round-robin pointer steps through the unmasked channels. It sits between parallel sensor/data lanes and a single downstream consumer, serialising one sample per accepted transfer.

Parameters:
CH, 4, number of input channels (2..16).
W, 8, data width per channel.
SELW, 2, select/pointer width; must equal clog2(CH).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
en  input  1  capture enable
mode  input  1  0 = manual (use sel), 1 = auto-scan (use internal pointer)
sel  input  SELW  manual channel select
mask  input  CH  scan-mode channel enable, bit i = channel i participates
din  input  CH*W  flattened inputs, channel i at din[i*W +: W]
dout  output  W  registered selected data
dout_ch  output  SELW  channel index that dout came from
dout_valid  output  1  dout/dout_ch hold an unaccepted sample
dout_ready  input  1  downstream accepts when high with dout_valid

Behaviour:
- Design rules:
  - Single clock, clk. Reset is synchronous and active-low (rst_n sampled only at the clk rising edge).
  - rst_n low at an edge clears state regardless of en, mode or handshake. This includes reset mid-transfer; no sample survives.
- Reset values: dout=0, dout_ch=0, dout_valid=0, internal scan pointer ptr=0, FSM=EMPTY.
- FSM states:
  - EMPTY (dout_valid=0) and FULL (dout_valid=1).
  - slot_free = (state==EMPTY) or (dout_ready==1).
  - load = en and slot_free and a channel is eligible (see below).
- Transitions:
  - EMPTY: load -> FULL. Otherwise stay.
  - FULL, dout_ready=0: stay. dout and dout_ch are held bit-stable.
  - FULL, dout_ready=1, load: stay FULL with the new sample. This is a back-to-back transfer with no bubble.
  - FULL, dout_ready=1, no load: -> EMPTY.
- Manual mode (mode=0):
  - Eligible iff sel < CH.
  - On load: dout <= din[sel], dout_ch <= sel.
  - sel >= CH (only possible when CH is not a power of two): no load.
  - ptr is unchanged in manual mode.
- Scan mode (mode=1):
  - c = first channel with mask[c]=1, searching ptr, ptr+1, ..., CH-1, 0, ..., ptr-1 (wrap-around).
  - Eligible iff mask != 0.
  - On load: dout <= din[c], dout_ch <= c, ptr <= (c+1) mod CH.
  - mask==0: no load, ptr is held.
  - mask changes take effect on the next load.
- Latency: one clock from the load edge to dout_valid/dout, using din sampled at that edge. din need not be held afterwards.
- Mode switch: takes effect at the next load. ptr is retained across manual periods. A pending FULL sample is never overwritten until accepted.
- en=0: no new loads. A pending sample still completes its handshake.
- Throughput: one sample per cycle when dout_ready is held high.
- Datapath is purely a selection; no arithmetic beyond the ptr increment, which wraps modulo CH (not modulo 2^SELW).

Test Plan:
- Reset and manual mode (CH=4, W=8):
  - Stimulus: rst_n=0 for 2 cycles, then mode=0, en=1, dout_ready=1, din={8'h44,8'h33,8'h22,8'h11}; sel stepped 0,1,2,3 one per cycle.
  - Required: dout_valid=0 and dout=0 during reset. Then dout=11,22,33,44 with dout_ch=0..3, each one cycle after its sel, dout_valid continuously 1.
- Backpressure:
  - Stimulus: manual sel=2, dout_ready=0 for 5 cycles while din[2] changes every cycle.
  - Required: dout is frozen at the first captured value (22), dout_valid=1. On dout_ready=1, the next cycle shows the fresh din[2].
- Scan with mask and wrap:
  - Stimulus: mode=1, mask=4'b1011, dout_ready=1, en=1 for 6 cycles.
  - Required: dout_ch sequence 0,1,3,0,1,3; channel 2 is never output.
- Empty mask, then resume:
  - Stimulus: scan with mask=0 for 3 cycles, then mask=4'b0100.
  - Required: after the last accept, dout_valid=0 and ptr is held. Then dout_ch=2 repeatedly.
- Reset mid-transfer:
  - Stimulus: FULL with dout_ready=0, then assert rst_n=0 for one edge.
  - Required: the next cycle has dout_valid=0, dout=0, dout_ch=0. The scan restarts at channel 0 (first unmasked at or after 0).
- Non-power-of-two configuration:
  - Stimulus: CH=3, SELW=2, manual sel=3.
  - Required: no load, dout_valid stays 0.
  - Stimulus: scan mode, mask=3'b111.
  - Required: dout_ch cycles 0,1,2,0.

Source files
------------

// File: rtl/mux_scan_n.sv
// N-channel registered mux: manual select or round-robin scan over unmasked channels.
// Latency: one clock from the load edge to dout/dout_valid; one sample per cycle with dout_ready high.
// Backpressure: a held sample stays bit-stable until accepted; no new load while full and not ready.
module mux_scan_n #(
    parameter int CH   = 4,
    parameter int W    = 8,
    parameter int SELW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [CH-1:0]     mask,
    input  logic [CH*W-1:0]   din,
    output logic [W-1:0]      dout,
    output logic [SELW-1:0]   dout_ch,
    output logic              dout_valid,
    input  logic              dout_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [SELW:0]   CH_W    = (SELW+1)'(CH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(CH - 1);

    state_t            state_q, state_d;
    logic [W-1:0]      dout_q, dout_d;
    logic [SELW-1:0]   ch_q, ch_d;
    logic [SELW-1:0]   ptr_q, ptr_d;

    logic [W-1:0]      lane [CH];
    logic              man_ok;
    logic [W-1:0]      man_dat;
    logic              scan_hit;
    logic [SELW-1:0]   scan_ch;
    logic [W-1:0]      scan_dat;
    logic              slot_free;
    logic              eligible;
    logic              load;

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            lane[i] = din[i*W +: W];
        end
    end

    // sel values at or above CH never match, so they simply leave man_ok low
    always_comb begin
        man_ok  = 1'b0;
        man_dat = '0;
        for (int i = 0; i < CH; i++) begin
            if (sel == SELW'(i)) begin
                man_ok  = 1'b1;
                man_dat = lane[i];
            end
        end
    end

    // Search ptr, ptr+1, ... with wrap at CH; one extra bit keeps the sum from overflowing.
    always_comb begin : scan_pick
        logic [SELW:0] sum;
        sum      = '0;
        scan_hit = 1'b0;
        scan_ch  = '0;
        scan_dat = '0;
        for (int k = 0; k < CH; k++) begin
            sum = {1'b0, ptr_q} + (SELW+1)'(k);
            if (sum >= CH_W) begin
                sum = sum - CH_W;
            end
            if (!scan_hit && mask[sum[SELW-1:0]]) begin
                scan_hit = 1'b1;
                scan_ch  = sum[SELW-1:0];
                scan_dat = lane[sum[SELW-1:0]];
            end
        end
    end

    always_comb begin
        slot_free = (state_q == EMPTY) || dout_ready;
        eligible  = mode ? scan_hit : man_ok;
        load      = en && slot_free && eligible;

        state_d = state_q;
        dout_d  = dout_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;

        if (load) begin
            state_d = FULL;
            if (mode) begin
                dout_d = scan_dat;
                ch_d   = scan_ch;
                ptr_d  = (scan_ch == LAST_CH) ? '0 : scan_ch + 1'b1;
            end else begin
                dout_d = man_dat;
                ch_d   = sel;
            end
        end else if (slot_free) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            dout_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = ch_q;
    assign dout_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: a CH=4 instance checked against a scoreboard plus per-scenario checks,
// and a CH=3 instance for the non-power-of-two select and scan wrap.
module tb_mux_scan_n;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, mode, dout_ready;
    logic [1:0]  sel;
    logic [3:0]  mask;
    logic [31:0] din;
    logic [7:0]  dout;
    logic [1:0]  dout_ch;
    logic        dout_valid;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  mask3;
    logic [23:0] din3;
    logic [7:0]  dout3;
    logic [1:0]  dout_ch3;
    logic        dout_valid3;

    mux_scan_n #(.CH(4), .W(8), .SELW(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .mask(mask), .din(din),
        .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    mux_scan_n #(.CH(3), .W(8), .SELW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode3), .sel(sel3), .mask(mask3), .din(din3),
        .dout(dout3), .dout_ch(dout_ch3), .dout_valid(dout_valid3), .dout_ready(dout_ready)
    );

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [9:0] sb_q[$];
    logic [9:0] sb_exp;
    bit         vm = 1'b0;
    int         ptr_m = 0;
    bit         mon_en = 1'b0;

    // Predict the load at the coming edge from the current inputs, push it, then advance the model.
    task automatic step();
        bit slot, ld;
        int c;
        slot = !vm || dout_ready;
        c = -1;
        if (mode) begin
            for (int i = 0; i < 4; i++) begin
                int idx;
                idx = (ptr_m + i) % 4;
                if (c < 0 && mask[idx]) c = idx;
            end
        end else begin
            c = int'(sel);
        end
        ld = rst_n && en && slot && (c >= 0);
        if (ld) sb_q.push_back({2'(c), din[c*8 +: 8]});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            vm = 1'b0;
            ptr_m = 0;
            sb_q.delete();
        end else if (ld) begin
            vm = 1'b1;
            if (mode) ptr_m = (c + 1) % 4;
        end else if (slot) begin
            vm = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            tests_run++;
            if (dout_valid !== vm) begin
                tests_failed++;
                $display("FAIL sb_valid got %b expected %b at %0t", dout_valid, vm, $time);
            end
            if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected got ch=%0d dat=%h expected no sample at %0t", dout_ch, dout, $time);
                end else begin
                    sb_exp = sb_q.pop_front();
                    if ({dout_ch, dout} !== sb_exp) begin
                        tests_failed++;
                        $display("FAIL sb_sample got ch=%0d dat=%h expected ch=%0d dat=%h at %0t",
                                 dout_ch, dout, sb_exp[9:8], sb_exp[7:0], $time);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 2'd0; mask = 4'd0; din = 32'd0; dout_ready = 1'b0;
        mode3 = 1'b0; sel3 = 2'd3; mask3 = 3'd0; din3 = 24'd0;
        step();
        mon_en = 1'b1;
        en = 1'b1; dout_ready = 1'b1;
        step();
        tests_run++;
        if (dout_valid !== 1'b0 || dout !== 8'h00 || dout_ch !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state got v=%b d=%h ch=%0d expected v=0 d=00 ch=0", dout_valid, dout, dout_ch);
        end
        tests_run++;
        if (dout_valid3 !== 1'b0 || dout3 !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state3 got v=%b d=%h expected v=0 d=00", dout_valid3, dout3);
        end
    endtask

    task automatic test_manual();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n = 1'b1; en = 1'b1; mode = 1'b0; dout_ready = 1'b1; din = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            tests_run++;
            if (dout_valid !== 1'b1 || dout !== exp_b[i] || dout_ch !== 2'(i)) begin
                tests_failed++;
                $display("FAIL manual_sel%0d got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d",
                         i, dout_valid, dout, dout_ch, exp_b[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        din[23:16] = 8'h22; sel = 2'd2;
        step();
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din[23:16] = 8'h50 + 8'(i);
            step();
            tests_run++;
            if (dout_valid !== 1'b1 || dout !== 8'h22 || dout_ch !== 2'd2) begin
                tests_failed++;
                $display("FAIL bp_hold%0d got v=%b d=%h ch=%0d expected v=1 d=22 ch=2", i, dout_valid, dout, dout_ch);
            end
        end
        dout_ready = 1'b1; din[23:16] = 8'hA5;
        step();
        tests_run++;
        if (dout !== 8'hA5 || dout_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release got v=%b d=%h expected v=1 d=a5", dout_valid, dout);
        end
    endtask

    task automatic test_scan_mask();
        int exp_ch [6];
        exp_ch = '{0, 1, 3, 0, 1, 3};
        din = 32'h44332211; mode = 1'b1; mask = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if (dout_ch !== 2'(exp_ch[i]) || dout !== din[exp_ch[i]*8 +: 8]) begin
                tests_failed++;
                $display("FAIL scan_mask%0d got ch=%0d d=%h expected ch=%0d d=%h",
                         i, dout_ch, dout, exp_ch[i], din[exp_ch[i]*8 +: 8]);
            end
        end
    endtask

    task automatic test_empty_mask();
        int exp_ch [3];
        mask = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (dout_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_mask%0d got v=%b expected v=0", i, dout_valid);
            end
        end
        mask = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (dout_valid !== 1'b1 || dout_ch !== 2'd2) begin
                tests_failed++;
                $display("FAIL resume_ch2_%0d got v=%b ch=%0d expected v=1 ch=2", i, dout_valid, dout_ch);
            end
        end
        mask = 4'b0000;
        step();
        exp_ch = '{3, 0, 1};
        mask = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (dout_ch !== 2'(exp_ch[i])) begin
                tests_failed++;
                $display("FAIL ptr_held%0d got ch=%0d expected ch=%0d", i, dout_ch, exp_ch[i]);
            end
        end
    endtask

    task automatic test_en_low();
        en = 1'b0; dout_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (dout_valid !== 1'b1 || dout_ch !== 2'd1) begin
                tests_failed++;
                $display("FAIL en_low_hold%0d got v=%b ch=%0d expected v=1 ch=1", i, dout_valid, dout_ch);
            end
        end
        dout_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (dout_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL en_low_drain%0d got v=%b expected v=0", i, dout_valid);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_mode_switch();
        mode = 1'b0; sel = 2'd3;
        step();
        tests_run++;
        if (dout_valid !== 1'b1 || dout_ch !== 2'd3) begin
            tests_failed++;
            $display("FAIL switch_manual got v=%b ch=%0d expected v=1 ch=3", dout_valid, dout_ch);
        end
        mode = 1'b1; mask = 4'b1111;
        step();
        tests_run++;
        if (dout_ch !== 2'd2) begin
            tests_failed++;
            $display("FAIL switch_scan got ch=%0d expected ch=2", dout_ch);
        end
    endtask

    task automatic test_reset_mid();
        dout_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        tests_run++;
        if (dout_valid !== 1'b0 || dout !== 8'h00 || dout_ch !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_mid got v=%b d=%h ch=%0d expected v=0 d=00 ch=0", dout_valid, dout, dout_ch);
        end
        rst_n = 1'b1; dout_ready = 1'b1; mask = 4'b1011;
        step();
        tests_run++;
        if (dout_ch !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_restart got ch=%0d expected ch=0", dout_ch);
        end
        step();
        tests_run++;
        if (dout_ch !== 2'd1) begin
            tests_failed++;
            $display("FAIL reset_restart2 got ch=%0d expected ch=1", dout_ch);
        end
    endtask

    task automatic test_back_to_back();
        mode = 1'b0; dout_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sel = 2'($urandom_range(0, 3));
            din = $urandom;
            step();
            tests_run++;
            if (dout_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_valid%0d got v=%b expected v=1", i, dout_valid);
            end
        end
    endtask

    task automatic test_npot();
        int exp_ch [4];
        step();
        tests_run++;
        if (dout_valid3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL npot_sel3 got v=%b expected v=0", dout_valid3);
        end
        exp_ch = '{0, 1, 2, 0};
        din3 = 24'hCCBBAA; mode3 = 1'b1; mask3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (dout_valid3 !== 1'b1 || dout_ch3 !== 2'(exp_ch[i]) || dout3 !== din3[exp_ch[i]*8 +: 8]) begin
                tests_failed++;
                $display("FAIL npot_scan%0d got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                         i, dout_valid3, dout_ch3, dout3, exp_ch[i], din3[exp_ch[i]*8 +: 8]);
            end
        end
    endtask

    task automatic test_drain();
        en = 1'b0; dout_ready = 1'b1;
        step();
        step();
        tests_run++;
        if (sb_q.size() != 0 || dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain got pending=%0d v=%b expected pending=0 v=0", sb_q.size(), dout_valid);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_backpressure();
        test_scan_mask();
        test_empty_mask();
        test_en_low();
        test_mode_switch();
        test_reset_mid();
        test_back_to_back();
        test_npot();
        test_drain();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
